// File: rtl/router_pkt_tx_pkg.sv
// Shared router definitions: header field layout, port limits and the transmitter state encoding.
package router_pkg;
  localparam int ADDR_W       = 2;
  localparam int MAX_PORT     = 2;
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEADER  = 3'd1,
    PAYLOAD = 3'd2,
    PARITY  = 3'd3,
    DONE    = 3'd4
  } state_t;
endpackage

// File: rtl/router_pkt_tx_if.sv
// Host command/buffer signals and the router byte stream of the packet transmitter.
interface router_pkt_tx_if #(
  parameter int DEPTH = 64,
  parameter int LEN_W = 6
) ();
  import router_pkg::*;

  // Byte stream: pkt_data is accepted by the router at any rising edge where busy=0;
  // the transmitter holds pkt_valid/pkt_data stable otherwise.
  logic                     host_wr_en;
  logic [7:0]               host_data;
  logic                     buf_full;
  logic [$clog2(DEPTH):0]   buf_count;
  logic                     send;
  logic [ADDR_W-1:0]        dest;
  logic [LEN_W-1:0]         len;
  logic                     tx_ready;
  logic                     busy;
  logic                     pkt_valid;
  logic [7:0]               pkt_data;
  logic                     tx_done;
  logic                     cmd_err;
  state_t                   fsm_state;

  modport master (
    input  host_wr_en, host_data, send, dest, len, busy,
    output buf_full, buf_count, tx_ready, pkt_valid, pkt_data, tx_done, cmd_err, fsm_state
  );

  modport slave (
    output host_wr_en, host_data, send, dest, len, busy,
    input  buf_full, buf_count, tx_ready, pkt_valid, pkt_data, tx_done, cmd_err, fsm_state
  );
endinterface

// File: rtl/router_pkt_tx_buf.sv
// First-word-fall-through payload FIFO: rd_data always shows the oldest buffered byte.
module pkt_tx_buf #(
  parameter int DEPTH = 64,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  input  logic                   rd_en,
  output logic [W-1:0]           rd_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == CNT_W'(DEPTH));
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && (count != '0);
  assign rd_data = mem[rd_ptr];

  // Storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/router_pkt_tx.sv
// Router packet transmitter: sends header, buffered payload and parity byte under busy back-pressure.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int LEN_W = 6
) (
  input logic            clk,
  input logic            rst,
  router_pkt_tx_if.master bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_t           state_q, state_d;
  logic             pkt_valid_q, pkt_valid_d;
  logic [7:0]       pkt_data_q, pkt_data_d;
  logic [7:0]       parity_q, parity_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             tx_done_q, tx_done_d;
  logic             cmd_err_q, cmd_err_d;
  logic             pop;
  logic [7:0]       head;
  logic             buf_full;
  logic [CNT_W-1:0] buf_count;
  logic             cmd_bad;
  logic [7:0]       hdr;

  pkt_tx_buf #(.DEPTH(DEPTH), .W(8)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.host_wr_en),
    .wr_data (bus.host_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (buf_full),
    .count   (buf_count)
  );

  assign hdr     = {bus.len, bus.dest};
  assign cmd_bad = (bus.len == '0) || (bus.dest > ADDR_W'(MAX_PORT)) ||
                   (CNT_W'(bus.len) > buf_count);

  // Each byte is popped as it is loaded into pkt_data, so the FIFO head is
  // already the next byte by the time the router accepts the current one.
  always_comb begin
    state_d     = state_q;
    pkt_valid_d = pkt_valid_q;
    pkt_data_d  = pkt_data_q;
    parity_d    = parity_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    tx_done_d   = 1'b0;
    cmd_err_d   = 1'b0;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.send) begin
          if (cmd_bad) begin
            cmd_err_d = 1'b1;
          end else begin
            state_d     = HEADER;
            len_d       = bus.len;
            pkt_valid_d = 1'b1;
            pkt_data_d  = hdr;
            parity_d    = hdr;
          end
        end
      end
      HEADER: begin
        if (!bus.busy) begin
          state_d    = PAYLOAD;
          pkt_data_d = head;
          pop        = 1'b1;
          cnt_d      = LEN_W'(1);
        end
      end
      PAYLOAD: begin
        if (!bus.busy) begin
          parity_d = parity_q ^ pkt_data_q;
          if (cnt_q == len_q) begin
            state_d     = PARITY;
            pkt_valid_d = 1'b0;
            pkt_data_d  = parity_q ^ pkt_data_q;
          end else begin
            pkt_data_d = head;
            pop        = 1'b1;
            cnt_d      = cnt_q + LEN_W'(1);
          end
        end
      end
      PARITY: begin
        if (!bus.busy) begin
          state_d    = DONE;
          pkt_data_d = 8'h00;
          tx_done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pkt_valid_q <= 1'b0;
      pkt_data_q  <= 8'h00;
      parity_q    <= 8'h00;
      cnt_q       <= '0;
      len_q       <= '0;
      tx_done_q   <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_data_q  <= pkt_data_d;
      parity_q    <= parity_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      tx_done_q   <= tx_done_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign bus.pkt_valid = pkt_valid_q;
  assign bus.pkt_data  = pkt_data_q;
  assign bus.tx_done   = tx_done_q;
  assign bus.cmd_err   = cmd_err_q;
  assign bus.tx_ready  = (state_q == IDLE);
  assign bus.buf_full  = buf_full;
  assign bus.buf_count = buf_count;
  assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: directed packets, a command table and randomized packets against a queue model.
module tb_router_pkt_tx;
  import router_pkg::*;

  localparam int DEPTH = 64;
  localparam int LEN_W = 6;
  localparam int BUDGET = 4000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  router_pkt_tx_if #(.DEPTH(DEPTH), .LEN_W(LEN_W)) bus ();
  router_pkt_tx #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [7:0] model_q[$];  // bytes the payload buffer should hold, oldest first
  logic [7:0] exp_q[$];    // bytes of the packet in flight, in wire order

  typedef struct {
    int         pre_push;
    logic [1:0] dest;
    logic [5:0] len;
    int         busy_pct;
    bit         exp_err;
  } cmd_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus.host_wr_en = 1'b1;
    bus.host_data  = b;
    if (model_q.size() < DEPTH) model_q.push_back(b);
    tick();
    bus.host_wr_en = 1'b0;
  endtask

  task automatic expect_err(input logic [1:0] d, input logic [5:0] l);
    bus.send = 1'b1; bus.dest = d; bus.len = l;
    tick();
    bus.send = 1'b0;
    check("cmd_err_pulse", 32'(bus.cmd_err), 32'd1);
    check("err_pkt_valid", 32'(bus.pkt_valid), 32'd0);
    check("err_tx_ready", 32'(bus.tx_ready), 32'd1);
    tick();
    check("cmd_err_clear", 32'(bus.cmd_err), 32'd0);
    check("err_tx_ready2", 32'(bus.tx_ready), 32'd1);
  endtask

  // Builds the expected packet from the buffer model, then checks the presented
  // byte every cycle and retires it only on cycles where busy=0.
  task automatic run_packet(input logic [1:0] d, input logic [5:0] l, input int busy_pct,
                            input bit push_during, input int hold_idx, input int hold_n);
    logic [7:0] par;
    logic [7:0] b;
    int idx, held, cyc;
    bit bz;
    exp_q.delete();
    par = {l, d};
    exp_q.push_back(par);
    for (int i = 0; i < int'(l); i++) begin
      b = model_q.pop_front();
      exp_q.push_back(b);
      par = par ^ b;
    end
    exp_q.push_back(par);
    bus.send = 1'b1; bus.dest = d; bus.len = l;
    tick();
    bus.send = 1'b0;
    check("tx_ready_low", 32'(bus.tx_ready), 32'd0);
    idx = 0; held = 0; cyc = 0;
    while (exp_q.size() != 0 && cyc < BUDGET) begin
      if (idx == hold_idx && held < hold_n) begin
        bz = 1'b1;
        held++;
      end else begin
        bz = ($urandom_range(99) < busy_pct);
      end
      bus.busy = bz;
      bus.host_wr_en = 1'b0;
      if (push_during && (model_q.size() + int'(l) < DEPTH)) begin
        b = 8'($urandom);
        bus.host_wr_en = 1'b1;
        bus.host_data  = b;
        model_q.push_back(b);
      end
      @(negedge clk);
      check("pkt_data", 32'(bus.pkt_data), 32'(exp_q[0]));
      check("pkt_valid", 32'(bus.pkt_valid), 32'(exp_q.size() > 1));
      check("tx_done_mid", 32'(bus.tx_done), 32'd0);
      if (!bz) begin
        void'(exp_q.pop_front());
        idx++;
      end
      tick();
      cyc++;
    end
    if (cyc >= BUDGET) begin
      checks++;
      errors++;
      $display("FAIL pkt_timeout: %0d bytes outstanding after %0d cycles", exp_q.size(), cyc);
    end
    bus.busy = 1'b0;
    bus.host_wr_en = 1'b0;
    check("tx_done_pulse", 32'(bus.tx_done), 32'd1);
    check("done_pkt_valid", 32'(bus.pkt_valid), 32'd0);
    check("done_pkt_data", 32'(bus.pkt_data), 32'd0);
    check("done_state", 32'(bus.fsm_state), 32'(DONE));
    tick();
    check("tx_done_clear", 32'(bus.tx_done), 32'd0);
    check("tx_ready_back", 32'(bus.tx_ready), 32'd1);
    check("buf_count_after", 32'(bus.buf_count), 32'(model_q.size()));
  endtask

  initial begin
    cmd_vec_t   vecs[7];
    logic [7:0] dir_vals[5];
    int n;
    logic [5:0] l;

    bus.host_wr_en = 1'b0; bus.host_data = 8'h00; bus.send = 1'b0;
    bus.dest = 2'd0; bus.len = 6'd0; bus.busy = 1'b0;

    // Reset values
    #12;
    check("rst_pkt_valid", 32'(bus.pkt_valid), 32'd0);
    check("rst_pkt_data", 32'(bus.pkt_data), 32'd0);
    check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_tx_done", 32'(bus.tx_done), 32'd0);
    check("rst_cmd_err", 32'(bus.cmd_err), 32'd0);
    check("rst_buf_count", 32'(bus.buf_count), 32'd0);
    check("rst_buf_full", 32'(bus.buf_full), 32'd0);
    check("rst_state", 32'(bus.fsm_state), 32'(IDLE));
    @(posedge clk); #1 rst = 1'b0;
    tick();

    // Directed packet with literal expectations: header {3,1}=0D, parity 0D^A1^B2^C3=DD
    dir_vals = '{8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'hDD};
    push_byte(8'hA1); push_byte(8'hB2); push_byte(8'hC3);
    check("dir_count", 32'(bus.buf_count), 32'd3);
    bus.send = 1'b1; bus.dest = 2'd1; bus.len = 6'd3;
    tick();
    bus.send = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("dir_byte", 32'(bus.pkt_data), 32'(dir_vals[i]));
      check("dir_valid", 32'(bus.pkt_valid), 32'(i < 4));
      tick();
    end
    check("dir_tx_done", 32'(bus.tx_done), 32'd1);
    tick();
    check("dir_buf_empty", 32'(bus.buf_count), 32'd0);
    check("dir_tx_ready", 32'(bus.tx_ready), 32'd1);
    model_q.delete();

    // Same packet, router busy for 3 cycles while B2 is presented
    push_byte(8'hA1); push_byte(8'hB2); push_byte(8'hC3);
    run_packet(2'd1, 6'd3, 0, 1'b0, 2, 3);

    // Command table: rejects and accepted sends interleaved with pushes
    vecs[0] = '{3, 2'd1, 6'd0, 0,  1'b1};
    vecs[1] = '{0, 2'd3, 6'd2, 0,  1'b1};
    vecs[2] = '{0, 2'd1, 6'd5, 0,  1'b1};
    vecs[3] = '{0, 2'd2, 6'd3, 30, 1'b0};
    vecs[4] = '{5, 2'd0, 6'd5, 50, 1'b0};
    vecs[5] = '{1, 2'd1, 6'd2, 0,  1'b1};
    vecs[6] = '{1, 2'd1, 6'd2, 20, 1'b0};
    foreach (vecs[k]) begin
      for (int p = 0; p < vecs[k].pre_push; p++) push_byte(8'($urandom));
      if (vecs[k].exp_err) expect_err(vecs[k].dest, vecs[k].len);
      else run_packet(vecs[k].dest, vecs[k].len, vecs[k].busy_pct, 1'b0, -1, 0);
    end

    // Host pushes every cycle during a 10-byte transmit; the next packet drains them
    for (int p = 0; p < 10; p++) push_byte(8'($urandom));
    run_packet(2'd1, 6'd10, 0, 1'b1, -1, 0);
    run_packet(2'd2, 6'(model_q.size()), 25, 1'b0, -1, 0);

    // Reset while a payload byte is on the wire
    for (int p = 0; p < 8; p++) push_byte(8'($urandom));
    bus.send = 1'b1; bus.dest = 2'd0; bus.len = 6'd8; bus.busy = 1'b0;
    tick();
    bus.send = 1'b0;
    tick(); tick();
    check("pre_rst_state", 32'(bus.fsm_state), 32'(PAYLOAD));
    #1 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(bus.pkt_valid), 32'd0);
    check("mid_rst_ready", 32'(bus.tx_ready), 32'd1);
    check("mid_rst_count", 32'(bus.buf_count), 32'd0);
    check("mid_rst_data", 32'(bus.pkt_data), 32'd0);
    model_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("no_tx_done", 32'(bus.tx_done), 32'd0);
      tick();
    end

    // Fill to capacity, drop one extra, send a max-length packet
    for (int p = 0; p < DEPTH + 1; p++) push_byte(8'($urandom));
    check("full_flag", 32'(bus.buf_full), 32'd1);
    check("full_count", 32'(bus.buf_count), 32'(DEPTH));
    run_packet(2'd2, 6'd63, 20, 1'b0, -1, 0);
    check("full_left_one", 32'(bus.buf_count), 32'd1);
    check("not_full", 32'(bus.buf_full), 32'd0);

    // Randomized packets and the occasional bad destination
    for (int k = 0; k < 25; k++) begin
      n = $urandom_range(0, 20);
      for (int p = 0; p < n; p++) push_byte(8'($urandom));
      if (model_q.size() == 0) push_byte(8'($urandom));
      if ($urandom_range(9) == 0) begin
        expect_err(2'd3, 6'd1);
      end else begin
        l = 6'($urandom_range(1, (model_q.size() > 63) ? 63 : model_q.size()));
        run_packet(2'($urandom_range(0, 2)), l, $urandom_range(0, 60),
                   1'($urandom_range(0, 1)), -1, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
